dram_arbiter: RTL and testbench

- Two-requester arbiter for the single-port data RAM (lpm_ram_dq: registered address/data/we, unregistered q).
- Requester 0 is the CPU data port; requester 1 is the loader/debug port.
- Owns the RAM address, write-data and write-enable pins. Serialises one complete read or write per grant with a req/ack handshake.
- Sits between the CPU core and the dram instance.

---
 rtl/dram_arbiter.sv | 135 +++++++++++++
 tb/tb_dram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter -- two-requester arbiter for the single-port data RAM
// (lpm_ram_dq: registered address/data/we, unregistered q).
//
// Requester 0 is the CPU data port and requester 1 is the loader/debug port.
// Each grant performs one complete read or write in four cycles
// (IDLE -> ISSUE -> WAIT -> ACK). All outputs are registered.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-low
//   rX_req             access request, held until rX_ack
//   rX_we              1 = write, 0 = read (stable while rX_req)
//   rX_addr/rX_wdata   address / write data (stable while rX_req)
//   rX_ack             one-cycle completion pulse
//   rX_rdata           read data, valid with rX_ack and held afterwards
//   mem_addr/wdata/we  RAM address, data and write enable
//   mem_rdata          RAM q
//   busy               1 whenever the FSM is not idle
//   grant_id           requester owning the current or last transaction
//
// Build option:
//   DRAM_ARBITER_RR_EN  defined: round-robin on simultaneous requests
//                       undefined: fixed priority, requester 0 wins
module dram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   last_grant;
  logic   op_write;
  logic   winner;

  // Winner is only consumed in IDLE when at least one request is present.
  always_comb begin
    winner = 1'b0;
`ifdef DRAM_ARBITER_RR_EN
    if (r0_req && r1_req)
      winner = ~last_grant;
    else
      winner = ~r0_req;
`else
    // History is still tracked in the fixed-priority build but is masked
    // off here so it never steers the selection.
    winner = ~r0_req | (last_grant & 1'b0);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      op_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            mem_addr   <= winner ? r1_addr  : r0_addr;
            mem_wdata  <= winner ? r1_wdata : r0_wdata;
            mem_we     <= winner ? r1_we    : r0_we;
            op_write   <= winner ? r1_we    : r0_we;
            grant_id   <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            state      <= ISSUE;
          end else begin
            mem_we <= 1'b0;
          end
        end
        ISSUE: begin
          // RAM registers address/data/we on this edge.
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // RAM q is unregistered and valid here for reads.
          if (!op_write) begin
            if (grant_id) r1_rdata <= mem_rdata;
            else          r0_rdata <= mem_rdata;
          end
          if (grant_id) r1_ack <= 1'b1;
          else          r0_ack <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          // Requests are deliberately not sampled here: the requester is
          // about to drop its req and must not be re-granted.
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter -- self-checking bench for dram_arbiter with a behavioural
// single-port RAM (registered address/data/we, unregistered q) and a
// transaction-level reference model (expected memory, arbitration choice,
// four-cycle access timeline).
module tb_dram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic          r0_req, r0_we, r0_ack;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_ack;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, busy, grant_id;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        model_last = 1'b1;

  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [AW-1:0] ram_addr_q = '0;

  dram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM: inputs registered on the clock edge, q unregistered.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    ram_addr_q <= mem_addr;
  end
  assign mem_rdata = ram[ram_addr_q];

  // Arbitration rule as a plain decision on who is asking.
  function automatic logic pick(input logic q0, input logic q1);
`ifdef DRAM_ARBITER_RR_EN
    if (q0 && q1) return ~model_last;
`endif
    if (q0) return 1'b0;
    return (q1 ? 1'b1 : 1'b0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    r0_req = 1'b0;
    r1_req = 1'b0;
    reset  = 1'b0;
    step();
    step();
    reset      = 1'b1;
    model_last = 1'b1;
  endtask

  // Drives one request and records what the DUT does over 12 samples.
  task automatic run_txn(input logic id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int drop_at,
                         output int ack_k, output int n_ack, output int n_we,
                         output int n_other, output logic gid_bad, output logic [DW-1:0] rd);
    ack_k = 0; n_ack = 0; n_we = 0; n_other = 0; gid_bad = 1'b0; rd = '0;
    if (id) begin r1_we = we; r1_addr = addr; r1_wdata = wd; r1_req = 1'b1; end
    else    begin r0_we = we; r0_addr = addr; r0_wdata = wd; r0_req = 1'b1; end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (mem_we === 1'b1) n_we++;
      if (busy === 1'b1 && grant_id !== id) gid_bad = 1'b1;
      if ((id ? r1_ack : r0_ack) === 1'b1) begin
        n_ack++;
        if (ack_k == 0) begin
          ack_k = k;
          rd = id ? r1_rdata : r0_rdata;
        end
        if (id) r1_req = 1'b0; else r0_req = 1'b0;
      end
      if ((id ? r0_ack : r1_ack) === 1'b1) n_other++;
      if (k == drop_at) begin
        if (id) r1_req = 1'b0; else r0_req = 1'b0;
      end
    end
    model_last = id;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_addr, mem_wdata); end
    n_checks++; if (r0_ack !== 1'b0 || r1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks got=%b%b want=00", r0_ack, r1_ack); end
    n_checks++; if (r0_rdata !== '0 || r1_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h want=0/0", r0_rdata, r1_rdata); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got=%b want=0", grant_id); end
    reset = 1'b1;
    model_last = 1'b1;
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_read();
    int ack_k, n_ack, n_we, n_other; logic gid_bad; logic [DW-1:0] rd;
    ram[16'h0010] = 16'h1234;
    ref_mem[16'h0010] = 16'h1234;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    n_checks++; if (ack_k != 3) begin n_fail++; $display("FAIL read_latency got=%0d want=3", ack_k); end
    n_checks++; if (n_ack != 1) begin n_fail++; $display("FAIL read_ack_width got=%0d want=1", n_ack); end
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL read_data got=%h want=1234", rd); end
    n_checks++; if (n_other != 0) begin n_fail++; $display("FAIL read_r1_ack got=%0d want=0", n_other); end
    n_checks++; if (n_we != 0) begin n_fail++; $display("FAIL read_mem_we got=%0d want=0", n_we); end
    n_checks++; if (r0_rdata !== 16'h1234) begin n_fail++; $display("FAIL read_hold got=%h want=1234", r0_rdata); end
  endtask

  task automatic test_write_read();
    int ack_k, n_ack, n_we, n_other; logic gid_bad; logic [DW-1:0] rd;
    run_txn(1'b1, 1'b1, 16'h00FF, 16'hA5A5, 0, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    ref_mem[16'h00FF] = 16'hA5A5;
    n_checks++; if (n_we != 1) begin n_fail++; $display("FAIL write_we_width got=%0d want=1", n_we); end
    n_checks++; if (ack_k != 3 || n_ack != 1) begin n_fail++; $display("FAIL write_ack got=k%0d/n%0d want=k3/n1", ack_k, n_ack); end
    n_checks++; if (gid_bad !== 1'b0) begin n_fail++; $display("FAIL write_grant_id got=bad want=1"); end
    n_checks++; if (r1_rdata !== 16'h0000) begin n_fail++; $display("FAIL write_rdata_kept got=%h want=0000", r1_rdata); end
    run_txn(1'b1, 1'b0, 16'h00FF, 16'h0000, 0, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    n_checks++; if (rd !== ref_mem[16'h00FF]) begin n_fail++; $display("FAIL wr_rd_data got=%h want=%h", rd, ref_mem[16'h00FF]); end
    n_checks++; if (n_we != 0) begin n_fail++; $display("FAIL wr_rd_mem_we got=%0d want=0", n_we); end
    n_checks++; if (gid_bad !== 1'b0) begin n_fail++; $display("FAIL wr_rd_grant_id got=bad want=1"); end
  endtask

  task automatic test_early_drop();
    int ack_k, n_ack, n_we, n_other; logic gid_bad; logic [DW-1:0] rd;
    run_txn(1'b0, 1'b1, 16'h0003, 16'h7777, 2, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    ref_mem[16'h0003] = 16'h7777;
    n_checks++; if (ack_k != 3 || n_ack != 1) begin n_fail++; $display("FAIL drop_ack got=k%0d/n%0d want=k3/n1", ack_k, n_ack); end
    n_checks++; if (ram[16'h0003] !== 16'h7777) begin n_fail++; $display("FAIL drop_commit got=%h want=7777", ram[16'h0003]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got=%b want=0", busy); end
    run_txn(1'b0, 1'b0, 16'h0003, 16'h0000, 0, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    n_checks++; if (rd !== 16'h7777) begin n_fail++; $display("FAIL drop_readback got=%h want=7777", rd); end
  endtask

  task automatic test_reset_mid_write();
    int ack_k, n_ack, n_we, n_other; logic gid_bad; logic [DW-1:0] rd;
    r0_we = 1'b1; r0_addr = 16'h0005; r0_wdata = 16'hBEEF; r0_req = 1'b1;
    step();
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_issue_we got=%b want=1", mem_we); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_async_we got=%b want=0", mem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b want=0", busy); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_async_addr got=%h want=0000", mem_addr); end
    r0_req = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    model_last = 1'b1;
    step();
    run_txn(1'b0, 1'b0, 16'h0005, 16'h0000, 0, ack_k, n_ack, n_we, n_other, gid_bad, rd);
    n_checks++; if (rd !== ref_mem[16'h0005]) begin n_fail++; $display("FAIL rst_prior_data got=%h want=%h", rd, ref_mem[16'h0005]); end
  endtask

  task automatic test_simultaneous();
    int unsigned last_cyc;
    int   waited;
    logic id, exp;
    logic [DW-1:0] rd;
    do_reset();
    r0_we = 1'b0; r0_addr = 16'h0001; r1_we = 1'b0; r1_addr = 16'h0002;
    r0_req = 1'b1; r1_req = 1'b1;
    last_cyc = cyc;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      do begin
        step();
        waited++;
      end while (r0_ack !== 1'b1 && r1_ack !== 1'b1 && waited < 12);
      n_checks++;
      if (r0_ack !== 1'b1 && r1_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL sim_timeout n=%0d got=no_ack want=ack", n);
        break;
      end
      id  = (r1_ack === 1'b1);
      exp = pick(r0_req, r1_req);
      if (id !== exp) begin n_fail++; $display("FAIL sim_order n=%0d got=%0d want=%0d last=%0d", n, id, exp, model_last); end
      model_last = exp;
      rd = id ? r1_rdata : r0_rdata;
      n_checks++; if (rd !== ref_mem[id ? 16'h0002 : 16'h0001]) begin n_fail++; $display("FAIL sim_data n=%0d got=%h want=%h", n, rd, ref_mem[id ? 16'h0002 : 16'h0001]); end
      if (n > 0) begin
        n_checks++; if (cyc - last_cyc != 4) begin n_fail++; $display("FAIL sim_gap n=%0d got=%0d want=4", n, cyc - last_cyc); end
      end
      last_cyc = cyc;
      if (n == 3) r0_req = 1'b0;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step(); step(); step();
  endtask

  task automatic test_random();
    logic pend [2]; logic pwe [2]; logic [AW-1:0] pa [2]; logic [DW-1:0] pd [2];
    int unsigned phase;
    logic win, cw, q0, q1, gid_model;
    logic [AW-1:0] ca; logic [DW-1:0] cd, rd;
    do_reset();
    phase = 0; win = 1'b0; cw = 1'b0; gid_model = 1'b0; ca = '0; cd = '0;
    for (int r = 0; r < 2; r++) begin pend[r] = 1'b0; pwe[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
    for (int c = 0; c < 400; c++) begin
      q0 = r0_req; q1 = r1_req;
      step();
      // Each access: grant edge, then three more edges before the arbiter may grant again.
      if (phase == 0) begin
        if (q0 || q1) begin
          win = pick(q0, q1); model_last = win; gid_model = win;
          cw = pwe[win]; ca = pa[win]; cd = pd[win];
          phase = 1;
        end
      end else begin
        phase = (phase == 3) ? 0 : phase + 1;
      end
      n_checks++; if (busy !== (phase != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, phase != 0); end
      n_checks++; if (r0_ack !== (phase == 3 && win == 1'b0)) begin n_fail++; $display("FAIL rnd_r0_ack c=%0d got=%b", c, r0_ack); end
      n_checks++; if (r1_ack !== (phase == 3 && win == 1'b1)) begin n_fail++; $display("FAIL rnd_r1_ack c=%0d got=%b", c, r1_ack); end
      n_checks++; if (mem_we !== (phase == 1 && cw)) begin n_fail++; $display("FAIL rnd_mem_we c=%0d got=%b want=%b", c, mem_we, phase == 1 && cw); end
      if (phase != 0) begin
        n_checks++; if (grant_id !== gid_model) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, grant_id, gid_model); end
      end
      if (phase == 1) begin
        n_checks++; if (mem_addr !== ca) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, mem_addr, ca); end
      end
      if (phase == 3) begin
        if (!cw) begin
          rd = win ? r1_rdata : r0_rdata;
          n_checks++; if (rd !== ref_mem[ca]) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rd, ref_mem[ca]); end
        end else begin
          ref_mem[ca] = cd;
        end
        pend[win] = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pwe[r]  = 1'($urandom_range(0, 1));
          pa[r]   = AW'($urandom_range(0, 15));
          pd[r]   = DW'($urandom);
        end
      end
      r0_req = pend[0]; r0_we = pwe[0]; r0_addr = pa[0]; r0_wdata = pd[0];
      r1_req = pend[1]; r1_we = pwe[1]; r1_addr = pa[1]; r1_wdata = pd[1];
    end
    r0_req = 1'b0; r1_req = 1'b0;
    step(); step(); step(); step(); step();
  endtask

  initial begin
    reset = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = DW'(i) ^ 16'h5A5A;
      ref_mem[i] = DW'(i) ^ 16'h5A5A;
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_early_drop();
    test_reset_mid_write();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
